// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and coordinate width, so the
// pixel-colour logic can reuse the same bounds as the sync generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int SYNC_ACTIVE_LOW = 1;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_hvsync_generator.sv
// Free-running VGA timing generator: beam counters, registered syncs aligned
// with the counters, and a combinational visible-area flag.
module vga_hvsync_generator #(
  parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BACK          = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT         = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BACK          = vga_timing_pkg::V_BACK,
  parameter int SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               display_on,
  output logic [vga_timing_pkg::COORD_W-1:0] hpos,
  output logic [vga_timing_pkg::COORD_W-1:0] vpos
);

  import vga_timing_pkg::*;

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] L_H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] L_V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] L_H_DISP   = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] L_V_DISP   = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] L_H_SS     = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] L_H_SE     = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] L_V_SS     = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] L_V_SE     = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic               L_SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [COORD_W-1:0] r_hpos;
  logic [COORD_W-1:0] r_vpos;
  logic               r_hsync;
  logic               r_vsync;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;
  logic               w_hsync_act;
  logic               w_vsync_act;

  // Next-state counters; wraps use >= so any unreachable value recovers to 0.
  always_comb begin
    w_h_wrap = (r_hpos >= L_H_LAST);
    w_v_wrap = (r_vpos >= L_V_LAST);
    w_h_next = '0;
    w_v_next = r_vpos;
    if (w_h_wrap) begin
      w_h_next = '0;
    end else begin
      w_h_next = r_hpos + 10'd1;
    end
    if (r_vpos > L_V_LAST) begin
      w_v_next = '0;
    end else if (w_h_wrap) begin
      if (w_v_wrap) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_vpos + 10'd1;
      end
    end else begin
      w_v_next = r_vpos;
    end
  end

  // Sync decode on next-state values so the registered syncs line up with hpos/vpos.
  always_comb begin
    w_hsync_act = (w_h_next >= L_H_SS) && (w_h_next <= L_H_SE);
    w_vsync_act = (w_v_next >= L_V_SS) && (w_v_next <= L_V_SE);
  end

  // Beam position and sync registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_hsync <= L_SYNC_IDLE;
      r_vsync <= L_SYNC_IDLE;
    end else begin
      r_hpos  <= w_h_next;
      r_vpos  <= w_v_next;
      r_hsync <= L_SYNC_IDLE ^ w_hsync_act;
      r_vsync <= L_SYNC_IDLE ^ w_vsync_act;
    end
  end

  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_on = (r_hpos < L_H_DISP) && (r_vpos < L_V_DISP);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Directed bench: full 640x480 instance for line-level timing, plus a tiny
// geometry instance (15x13 clocks) so whole frames fit in a short run.
module tb_vga_hvsync_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de;
  logic [9:0] d_h, d_v;
  logic       s_hs, s_vs, s_de;
  logic [9:0] s_h, s_v;

  int n_vec = 0;
  int n_err = 0;

  vga_hvsync_generator dut (
    .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs),
    .display_on(d_de), .hpos(d_h), .vpos(d_v)
  );

  // Small geometry: H 8/2/3/2 = 15 (sync 10..12), V 6/2/2/3 = 13 (sync 8..9).
  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE_LOW(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .hsync(s_hs), .vsync(s_vs),
    .display_on(s_de), .hpos(s_h), .vpos(s_v)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      step();
      n_vec++;
      if ({d_h, d_v, d_hs, d_vs, d_de} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL reset_hold: got h=%0d v=%0d hs=%b vs=%b de=%b want 0 0 1 1 1", d_h, d_v, d_hs, d_vs, d_de);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) step();
    n_vec++;
    if (d_h !== 10'd7 || s_h !== 10'd7) begin
      n_err++;
      $display("FAIL count_after_release: got h=%0d hs_small=%0d want 7", d_h, s_h);
    end
    repeat (8) step();
    n_vec++;
    if (s_h !== 10'd0 || s_v !== 10'd1) begin
      n_err++;
      $display("FAIL small_line_wrap: got (%0d,%0d) want (0,1)", s_h, s_v);
    end
    // Assert reset between edges; outputs must clear with no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({d_h, d_v, d_hs, d_vs, d_de} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_async: got h=%0d v=%0d hs=%b vs=%b de=%b want 0 0 1 1 1", d_h, d_v, d_hs, d_vs, d_de);
    end
    n_vec++;
    if ({s_h, s_v, s_hs, s_vs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_async_small: got h=%0d v=%0d hs=%b vs=%b want 0 0 1 1", s_h, s_v, s_hs, s_vs);
    end
  endtask

  task automatic test_line_timing();
    int   lo_cnt = 0;
    int   fall_at = -1;
    int   rise_at = -1;
    logic prev_hs;
    int   eh, ev;
    logic exp_hs, exp_de;
    reset_release();
    prev_hs = d_hs;
    for (int k = 1; k <= 1700; k++) begin
      step();
      eh = k % 800;
      ev = k / 800;
      exp_hs = !(eh >= 656 && eh <= 751);
      exp_de = (eh < 640) && (ev < 480);
      n_vec++;
      if (d_h !== 10'(eh) || d_v !== 10'(ev)) begin
        n_err++;
        $display("FAIL line_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, d_h, d_v, eh, ev);
      end
      n_vec++;
      if (d_hs !== exp_hs || d_vs !== 1'b1) begin
        n_err++;
        $display("FAIL line_sync k=%0d: got hs=%b vs=%b want hs=%b vs=1", k, d_hs, d_vs, exp_hs);
      end
      n_vec++;
      if (d_de !== exp_de) begin
        n_err++;
        $display("FAIL line_display_on k=%0d h=%0d: got %b want %b", k, d_h, d_de, exp_de);
      end
      if (k < 800 && d_hs === 1'b0) lo_cnt++;
      if (prev_hs === 1'b1 && d_hs === 1'b0 && fall_at < 0) fall_at = int'(d_h);
      if (prev_hs === 1'b0 && d_hs === 1'b1 && rise_at < 0) rise_at = int'(d_h);
      prev_hs = d_hs;
    end
    n_vec++;
    if (lo_cnt != 96 || fall_at != 656 || rise_at != 752) begin
      n_err++;
      $display("FAIL hsync_pulse: got low=%0d fall=%0d rise=%0d want 96 656 752", lo_cnt, fall_at, rise_at);
    end
  endtask

  task automatic test_frame();
    int   hs_falls = 0;
    int   vs_falls = 0;
    int   last_fall = -1;
    logic prev_hs, prev_vs;
    int   eh, ev;
    logic exp_hs, exp_vs, exp_de;
    reset_release();
    prev_hs = s_hs;
    prev_vs = s_vs;
    for (int k = 1; k <= 3 * 195; k++) begin
      step();
      eh = k % 15;
      ev = (k / 15) % 13;
      exp_hs = !(eh >= 10 && eh <= 12);
      exp_vs = !(ev >= 8 && ev <= 9);
      exp_de = (eh < 8) && (ev < 6);
      n_vec++;
      if (s_h !== 10'(eh) || s_v !== 10'(ev)) begin
        n_err++;
        $display("FAIL frame_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, s_h, s_v, eh, ev);
      end
      n_vec++;
      if (s_hs !== exp_hs || s_vs !== exp_vs || s_de !== exp_de) begin
        n_err++;
        $display("FAIL frame_outs k=%0d (%0d,%0d): got hs=%b vs=%b de=%b want %b %b %b",
                 k, s_h, s_v, s_hs, s_vs, s_de, exp_hs, exp_vs, exp_de);
      end
      n_vec++;
      if (s_h > 10'd14 || s_v > 10'd12 || d_h > 10'd799 || d_v > 10'd524) begin
        n_err++;
        $display("FAIL bounds k=%0d: got small (%0d,%0d) full (%0d,%0d) want within totals", k, s_h, s_v, d_h, d_v);
      end
      if (prev_hs === 1'b1 && s_hs === 1'b0) hs_falls++;
      if (prev_vs === 1'b1 && s_vs === 1'b0) begin
        vs_falls++;
        n_vec++;
        if (s_h !== 10'd0 || s_v !== 10'd8) begin
          n_err++;
          $display("FAIL vsync_fall_pos: got (%0d,%0d) want (0,8)", s_h, s_v);
        end
        if (last_fall >= 0) begin
          n_vec++;
          if (k - last_fall != 195) begin
            n_err++;
            $display("FAIL frame_period: got %0d want 195", k - last_fall);
          end
        end
        last_fall = k;
      end
      if (prev_vs === 1'b0 && s_vs === 1'b1) begin
        n_vec++;
        if (s_h !== 10'd0 || s_v !== 10'd10) begin
          n_err++;
          $display("FAIL vsync_rise_pos: got (%0d,%0d) want (0,10)", s_h, s_v);
        end
      end
      prev_hs = s_hs;
      prev_vs = s_vs;
    end
    n_vec++;
    if (hs_falls != 39 || vs_falls != 3) begin
      n_err++;
      $display("FAIL pulse_counts: got hs=%0d vs=%0d want 39 3", hs_falls, vs_falls);
    end
  endtask

  task automatic test_mid_frame_reset();
    int   first_fall = -1;
    int   second_fall = -1;
    logic prev_vs;
    reset_release();
    repeat (1100) step();
    n_vec++;
    if (d_h !== 10'd300 || d_v !== 10'd1) begin
      n_err++;
      $display("FAIL mid_reach: got (%0d,%0d) want (300,1)", d_h, d_v);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({d_h, d_v, d_hs, d_vs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset_async: got h=%0d v=%0d hs=%b vs=%b want 0 0 1 1", d_h, d_v, d_hs, d_vs);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_vs = s_vs;
    for (int k = 1; k <= 330; k++) begin
      step();
      if (prev_vs === 1'b1 && s_vs === 1'b0) begin
        if (first_fall < 0) first_fall = k;
        else if (second_fall < 0) second_fall = k;
      end
      prev_vs = s_vs;
    end
    n_vec++;
    if (first_fall != 120 || second_fall != 315) begin
      n_err++;
      $display("FAIL mid_reset_frame: got falls at %0d,%0d want 120,315", first_fall, second_fall);
    end
    n_vec++;
    if (d_h !== 10'd330 || d_v !== 10'd0) begin
      n_err++;
      $display("FAIL mid_reset_restart: got (%0d,%0d) want (330,0)", d_h, d_v);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_hvsync_generator.md
Name: vga_hvsync_generator

Overview:
- Free-running VGA timing generator for 640x480 at 60 Hz.
- Pixel clock is nominally 25.175 MHz; the 24–25 MHz project clock is accepted.
- Produces hsync and vsync, the current beam position (hpos, vpos) and a display_on flag.
- Feeds the pixel-colour logic and the TinyVGA PMOD output mapping in the top-level VGA project.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are driven low (negative polarity, standard for 640x480)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- display_on  out  1  high while (hpos, vpos) is inside the visible area
- hpos  out  10  current column, 0..799
- vpos  out  10  current line, 0..524

Behaviour:
- Derived constants:
  - H_TOTAL = 640+16+96+48 = 800
  - V_TOTAL = 480+10+2+33 = 525
  - H_SYNC_START = 656, H_SYNC_END = 751
  - V_SYNC_START = 490, V_SYNC_END = 491
- Reset (rst_n low, asynchronous, takes effect immediately):
  - hpos = 0, vpos = 0
  - hsync = 1, vsync = 1 (inactive levels for SYNC_ACTIVE_LOW = 1)
  - display_on therefore reads 1
- Horizontal counter:
  - hpos increments by 1 every clk.
  - At hpos == 799 the next value is 0.
- Vertical counter:
  - vpos increments only on the clock where hpos wraps 799 -> 0.
  - At hpos == 799 and vpos == 524, both become 0 on the same edge (frame wrap).
- Frame length is exactly 800*525 = 420000 clocks; line length is exactly 800 clocks.
- hsync and vsync are registered from the next-state counter values, so they align with hpos/vpos in the same cycle with zero skew:
  - hsync is active (low) iff 656 <= hpos <= 751: 96 clocks per line.
  - vsync is active (low) iff 490 <= vpos <= 491: 2 full lines, 1600 clocks.
  - vsync changes only on the edge where hpos becomes 0.
- display_on = (hpos < 640) && (vpos < 480). It is combinational from the registered counters, with no extra latency.
- No enable or stall input: the counters never pause; they only restart on reset.
- Reset released mid-frame: counting restarts from (0,0) on the first rising edge after deassertion. No partial-frame recovery is required.
- Counter values above the totals are unreachable. If they ever occur, the next state is 0 (defensive wrap on >=, not ==).
- With SYNC_ACTIVE_LOW = 0, all sync levels are inverted, including the reset levels.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the eight timing localparams and the derived H_TOTAL, V_TOTAL and SYNC_START/END values
  - the 10-bit coordinate width, so pixel logic can reuse the same bounds
- No sub-module is needed: two counters plus sync/display decode form a single flat module.

Test Plan:
- Reset: hold rst_n low for 5 clocks, then release. Required while low: hpos = 0, vpos = 0, hsync = 1, vsync = 1, display_on = 1. Assert rst_n low asynchronously between edges; outputs must go to reset values without waiting for clk.
- Line timing: count from release. Required: hpos reaches 799 at clock 799, then wraps to 0; vpos becomes 1 on the same edge. hsync falls exactly when hpos = 656 and rises when hpos = 752. Low time is 96 clocks per line.
- display_on edges:
  - display_on = 1 for hpos 0..639, falls at hpos = 640, returns at hpos = 0.
  - On vpos 480..524, display_on stays 0 for the entire line.
- Vertical sync and frame:
  - vsync falls when (hpos, vpos) = (0, 490) and rises at (0, 492).
  - After (799, 524), the next state is (0, 0).
  - Successive vsync falling edges are exactly 420000 clocks apart.
- Mid-frame reset: run to (300, 200), pulse rst_n low for 1 clock. Required: immediately (0, 0), syncs inactive; the next full frame again measures 420000 clocks.
- Long run: simulate 3 frames while checking each cycle. Required:
  - hpos <= 799 and vpos <= 524 at all times.
  - Exactly 525 hsync pulses and 1 vsync pulse per frame.
